multicycle_processor: RTL and testbench
=======================================

Name: multicycle_processor

Overview:
- Parametrised multi-cycle MIPS-subset core. Executes one instruction over 2–5 states, driven by an explicit FSM.
- Shares one external word-addressed memory port for fetch and data, using a req/ready handshake so memory may insert wait states.
- Reuses the existing register file and ALU. Adds sign-extended immediates, J, ADDI and instruction-retire tracking.

Parameters:
- WORD_SIZE, 32, datapath width. Must be ≥32.
- ADDR_WIDTH, 8, memory word-address bits. Byte PC bits [ADDR_WIDTH+1:2] drive mem_addr.
- RESET_PC, 0, byte PC value loaded on reset.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- mem_req  out  1  memory access request
- mem_we  out  1  1 = write, 0 = read; valid while mem_req
- mem_addr  out  ADDR_WIDTH  word address
- mem_wdata  out  WORD_SIZE  store data
- mem_rdata  in  WORD_SIZE  read data; valid in the cycle mem_ready=1
- mem_ready  in  1  transfer completes at the edge where mem_req&mem_ready
- prog_count  out  WORD_SIZE  current PC
- instr_opcode  out  6  IR[31:26]
- fsm_state  out  3  current state encoding
- write_reg_en  out  1  register-file write strobe (post $0 gating)
- write_reg_addr  out  5  destination register
- write_reg_data  out  WORD_SIZE  data being written
- instr_retired  out  1  one-cycle pulse in the final state of each instruction

Behaviour:
- Reset: clk and rst only; rst sampled on the rising edge.
  - Loads PC=RESET_PC, IR=0, A=B=ALUOut=MDR=0, state=FETCH.
  - While rst=1, all outputs except prog_count/fsm_state/instr_opcode are forced to 0.
  - Reset mid-transfer abandons the access; no register or PC update.
- States (encoding 0–5):
  - FETCH: mem_req=1, mem_we=0, mem_addr=PC word address. Hold until mem_ready. Then IR<=mem_rdata, PC<=PC+4, go to DECODE.
  - DECODE: A<=R[rs], B<=R[rt], ALUOut<=PC+(sext(imm)<<2). Next state by opcode:
    - R-type, LW, SW, ADDI → EXEC
    - BEQ → BRANCH
    - J → PC<={PC[31:28],IR[25:0],2'b00}, retire, FETCH
    - Unknown opcode → NOP: retire, FETCH
  - EXEC: ALUOut<=A op (R-type ? B : sext(imm)). Op comes from the funct field for R-type; ADD for LW/SW/ADDI. LW/SW → MEM; R-type/ADDI → WB.
  - MEM: mem_req=1, mem_addr=ALUOut word address, mem_we=(SW), mem_wdata=B. Hold until mem_ready. LW: MDR<=mem_rdata → WB. SW: retire → FETCH.
  - WB: write ALUOut (R-type/ADDI) or MDR (LW). Destination is rd for R-type, rt otherwise. Retire → FETCH.
  - BRANCH: if A==B then PC<=ALUOut. Retire → FETCH.
- Handshake:
  - addr/we/wdata stay stable while mem_req=1 and ready=0.
  - mem_ready is ignored when mem_req=0.
  - Unbounded wait permitted.
- Zero-wait latency: J/NOP 2, BEQ 3, R-type/ADDI/SW 4, LW 5 cycles.
- Widths and arithmetic:
  - Immediates are sign-extended to WORD_SIZE.
  - PC+4 wraps modulo 2^WORD_SIZE.
  - Byte-address bits [1:0] and bits above ADDR_WIDTH+1 are discarded when forming mem_addr. No misalignment trap.
- Register $0: write_reg_en forced to 0 when the destination is 0; reads return 0.
- Overflow on ADD/ADDI is ignored (no exception).

Optional Feature:
- Macro: MCP_PERF_CNT_EN.
- When defined:
  - Adds outputs cycle_count and retire_count, each 32 bits, both reset to 0.
  - cycle_count increments every non-reset cycle.
  - retire_count increments on instr_retired.
  - Both wrap at 2^32.
- When undefined: the ports and counters are absent.

Decomposition:
- Shared package (existing CPU constant library), extended with:
  - opcode constants: RTYPE, LW, SW, BEQ, ADDI, J
  - FSM state encodings
  - funct and ALU-op codes
- Sub-module multicycle_control: FSM plus decode. Outputs per-state enables (ir_we, pc_we, pc_src, mem_req, mem_we, iord, alu_src_a/b, reg_write, mem_to_reg, reg_dst, retire).
- The datapath stays in the top module.

Test Plan:
- Reset with RESET_PC=0x40 → first mem_addr=0x10, mem_req=1, fsm_state=0, all debug write outputs 0.
- ADDI $1,$0,-3 then ADD $2,$1,$1 with zero-wait memory:
  - first write: write_reg_addr=1, data 0xFFFFFFFD
  - second write: addr=2, data 0xFFFFFFFA
  - retire pulses at cycles 4 and 8
- SW $2,8($0) then LW $3,8($0):
  - write cycle: mem_we=1, mem_addr=2, mem_wdata=0xFFFFFFFA
  - LW writes $3=0xFFFFFFFA after 5 cycles
- BEQ taken at PC=0x0C, offset -1 → next fetch PC=0x0C. BEQ not taken → PC=0x10. Both take 3 cycles.
- mem_ready held low 3 cycles during FETCH and during a LW MEM → outputs stable, PC/IR unchanged until ready; latency +3 each.
- Assert rst in the MEM state of a SW → no memory write accepted, PC=RESET_PC next cycle. ADD to $0 → write_reg_en=0.

Source files
------------

// File: rtl/multicycle_processor_pkg.sv
// Shared CPU constant library for the multicycle MIPS-subset core:
// opcodes, funct codes, FSM state encodings, ALU operations and the control word.
package multicycle_processor_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_BRANCH = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_AND  = 3'd2,
        ALU_OR   = 3'd3,
        ALU_XOR  = 3'd4,
        ALU_NOR  = 3'd5,
        ALU_SLT  = 3'd6,
        ALU_SLTU = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        PC_SRC_ALU    = 2'd0,
        PC_SRC_JUMP   = 2'd1,
        PC_SRC_ALUOUT = 2'd2
    } pc_src_e;

    typedef enum logic {
        SRC_A_PC  = 1'b0,
        SRC_A_REG = 1'b1
    } src_a_e;

    typedef enum logic [1:0] {
        SRC_B_REG    = 2'd0,
        SRC_B_FOUR   = 2'd1,
        SRC_B_IMM    = 2'd2,
        SRC_B_IMM_SH = 2'd3
    } src_b_e;

    typedef struct packed {
        logic    ir_we;
        logic    pc_we;
        pc_src_e pc_src;
        logic    mem_req;
        logic    mem_we;
        logic    iord;
        src_a_e  alu_src_a;
        src_b_e  alu_src_b;
        alu_op_e alu_op;
        logic    ab_we;
        logic    aluout_we;
        logic    mdr_we;
        logic    reg_write;
        logic    mem_to_reg;
        logic    reg_dst;
        logic    retire;
    } ctl_t;

    // Unknown funct codes fall back to ADD so the core never stalls on them.
    function automatic alu_op_e funct_to_alu_op(input logic [5:0] funct);
        alu_op_e op;
        case (funct)
            FN_ADD, FN_ADDU: op = ALU_ADD;
            FN_SUB, FN_SUBU: op = ALU_SUB;
            FN_AND:          op = ALU_AND;
            FN_OR:           op = ALU_OR;
            FN_XOR:          op = ALU_XOR;
            FN_NOR:          op = ALU_NOR;
            FN_SLT:          op = ALU_SLT;
            FN_SLTU:         op = ALU_SLTU;
            default:         op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/multicycle_control.sv
// Control FSM and instruction decode for multicycle_processor: produces the
// per-state enable word consumed by the datapath in the top module.
module multicycle_control
    import multicycle_processor_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    input  logic       a_eq_b,
    output state_e     state,
    output ctl_t       ctl
);

    state_e state_q;
    state_e state_d;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection and per-state datapath enables
    always_comb begin
        state_d = state_q;
        ctl     = '0;
        case (state_q)
            ST_FETCH: begin
                ctl.mem_req   = 1'b1;
                ctl.alu_src_a = SRC_A_PC;
                ctl.alu_src_b = SRC_B_FOUR;
                if (mem_ready) begin
                    ctl.ir_we  = 1'b1;
                    ctl.pc_we  = 1'b1;
                    ctl.pc_src = PC_SRC_ALU;
                    state_d    = ST_DECODE;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DECODE: begin
                // PC already points past this instruction, so this is the branch target
                ctl.ab_we     = 1'b1;
                ctl.aluout_we = 1'b1;
                ctl.alu_src_a = SRC_A_PC;
                ctl.alu_src_b = SRC_B_IMM_SH;
                case (opcode)
                    OP_RTYPE, OP_LW, OP_SW, OP_ADDI: state_d = ST_EXEC;
                    OP_BEQ:  state_d = ST_BRANCH;
                    OP_J: begin
                        ctl.pc_we  = 1'b1;
                        ctl.pc_src = PC_SRC_JUMP;
                        ctl.retire = 1'b1;
                        state_d    = ST_FETCH;
                    end
                    default: begin
                        ctl.retire = 1'b1;
                        state_d    = ST_FETCH;
                    end
                endcase
            end
            ST_EXEC: begin
                ctl.aluout_we = 1'b1;
                ctl.alu_src_a = SRC_A_REG;
                if (opcode == OP_RTYPE) begin
                    ctl.alu_src_b = SRC_B_REG;
                    ctl.alu_op    = funct_to_alu_op(funct);
                end else begin
                    ctl.alu_src_b = SRC_B_IMM;
                    ctl.alu_op    = ALU_ADD;
                end
                if ((opcode == OP_LW) || (opcode == OP_SW)) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                ctl.mem_req = 1'b1;
                ctl.iord    = 1'b1;
                ctl.mem_we  = (opcode == OP_SW);
                if (mem_ready) begin
                    if (opcode == OP_SW) begin
                        ctl.retire = 1'b1;
                        state_d    = ST_FETCH;
                    end else begin
                        ctl.mdr_we = 1'b1;
                        state_d    = ST_WB;
                    end
                end else begin
                    state_d = ST_MEM;
                end
            end
            ST_WB: begin
                ctl.reg_write  = 1'b1;
                ctl.mem_to_reg = (opcode == OP_LW);
                ctl.reg_dst    = (opcode == OP_RTYPE);
                ctl.retire     = 1'b1;
                state_d        = ST_FETCH;
            end
            ST_BRANCH: begin
                ctl.retire = 1'b1;
                if (a_eq_b) begin
                    ctl.pc_we  = 1'b1;
                    ctl.pc_src = PC_SRC_ALUOUT;
                end else begin
                    ctl.pc_we = 1'b0;
                end
                state_d = ST_FETCH;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    assign state = state_q;

endmodule

// File: rtl/multicycle_processor.sv
// Multicycle MIPS-subset core: datapath, register file and shared memory port.
// Optional performance counters are enabled by defining MCP_PERF_CNT_EN.
module multicycle_processor
    import multicycle_processor_pkg::*;
#(
    parameter int unsigned          WORD_SIZE  = 32,
    parameter int unsigned          ADDR_WIDTH = 8,
    parameter logic [WORD_SIZE-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WORD_SIZE-1:0]  mem_wdata,
    input  logic [WORD_SIZE-1:0]  mem_rdata,
    input  logic                  mem_ready,
    output logic [WORD_SIZE-1:0]  prog_count,
    output logic [5:0]            instr_opcode,
    output logic [2:0]            fsm_state,
    output logic                  write_reg_en,
    output logic [4:0]            write_reg_addr,
    output logic [WORD_SIZE-1:0]  write_reg_data,
    output logic                  instr_retired
`ifdef MCP_PERF_CNT_EN
    ,
    output logic [31:0]           cycle_count,
    output logic [31:0]           retire_count
`endif
);

    logic [WORD_SIZE-1:0] pc_q, pc_d;
    logic [31:0]          ir_q, ir_d;
    logic [WORD_SIZE-1:0] a_q, a_d;
    logic [WORD_SIZE-1:0] b_q, b_d;
    logic [WORD_SIZE-1:0] aluout_q, aluout_d;
    logic [WORD_SIZE-1:0] mdr_q, mdr_d;
    logic [WORD_SIZE-1:0] rf_q [32];
    logic [WORD_SIZE-1:0] rf_d [32];

    ctl_t                 ctl_s;
    state_e               state_s;
    logic [4:0]           rs_s, rt_s, rd_s;
    logic [WORD_SIZE-1:0] rs_val_s, rt_val_s;
    logic [WORD_SIZE-1:0] imm_sext_s, imm_sh_s, jump_tgt_s;
    logic [WORD_SIZE-1:0] alu_a_s, alu_b_s, alu_res_s;
    logic [4:0]           wr_addr_s;
    logic [WORD_SIZE-1:0] wr_data_s;
    logic                 wr_en_s;

    multicycle_control u_control (
        .clk       (clk),
        .rst       (rst),
        .opcode    (ir_q[31:26]),
        .funct     (ir_q[5:0]),
        .mem_ready (mem_ready),
        .a_eq_b    (a_q == b_q),
        .state     (state_s),
        .ctl       (ctl_s)
    );

    assign rs_s       = ir_q[25:21];
    assign rt_s       = ir_q[20:16];
    assign rd_s       = ir_q[15:11];
    assign rs_val_s   = (rs_s == 5'd0) ? '0 : rf_q[rs_s];
    assign rt_val_s   = (rt_s == 5'd0) ? '0 : rf_q[rt_s];
    assign imm_sext_s = {{(WORD_SIZE-16){ir_q[15]}}, ir_q[15:0]};
    assign imm_sh_s   = {{(WORD_SIZE-18){ir_q[15]}}, ir_q[15:0], 2'b00};
    assign jump_tgt_s = {pc_q[WORD_SIZE-1:28], ir_q[25:0], 2'b00};

    assign wr_addr_s  = ctl_s.reg_dst ? rd_s : rt_s;
    assign wr_data_s  = ctl_s.mem_to_reg ? mdr_q : aluout_q;
    assign wr_en_s    = ctl_s.reg_write && (wr_addr_s != 5'd0);

    // Shared ALU: operand selection and operation
    always_comb begin
        alu_a_s   = (ctl_s.alu_src_a == SRC_A_REG) ? a_q : pc_q;
        alu_b_s   = '0;
        alu_res_s = '0;
        case (ctl_s.alu_src_b)
            SRC_B_REG:    alu_b_s = b_q;
            SRC_B_FOUR:   alu_b_s = WORD_SIZE'(3'd4);
            SRC_B_IMM:    alu_b_s = imm_sext_s;
            SRC_B_IMM_SH: alu_b_s = imm_sh_s;
            default:      alu_b_s = '0;
        endcase
        case (ctl_s.alu_op)
            ALU_ADD:  alu_res_s = alu_a_s + alu_b_s;
            ALU_SUB:  alu_res_s = alu_a_s - alu_b_s;
            ALU_AND:  alu_res_s = alu_a_s & alu_b_s;
            ALU_OR:   alu_res_s = alu_a_s | alu_b_s;
            ALU_XOR:  alu_res_s = alu_a_s ^ alu_b_s;
            ALU_NOR:  alu_res_s = ~(alu_a_s | alu_b_s);
            ALU_SLT:  alu_res_s = {{(WORD_SIZE-1){1'b0}}, ($signed(alu_a_s) < $signed(alu_b_s))};
            ALU_SLTU: alu_res_s = {{(WORD_SIZE-1){1'b0}}, (alu_a_s < alu_b_s)};
            default:  alu_res_s = alu_a_s + alu_b_s;
        endcase
    end

    // Next values of PC and the holding registers between states
    always_comb begin
        pc_d     = pc_q;
        ir_d     = ir_q;
        a_d      = a_q;
        b_d      = b_q;
        aluout_d = aluout_q;
        mdr_d    = mdr_q;
        if (ctl_s.pc_we) begin
            case (ctl_s.pc_src)
                PC_SRC_ALU:    pc_d = alu_res_s;
                PC_SRC_JUMP:   pc_d = jump_tgt_s;
                PC_SRC_ALUOUT: pc_d = aluout_q;
                default:       pc_d = pc_q;
            endcase
        end else begin
            pc_d = pc_q;
        end
        if (ctl_s.ir_we) begin
            ir_d = mem_rdata[31:0];
        end else begin
            ir_d = ir_q;
        end
        if (ctl_s.ab_we) begin
            a_d = rs_val_s;
            b_d = rt_val_s;
        end else begin
            a_d = a_q;
            b_d = b_q;
        end
        if (ctl_s.aluout_we) begin
            aluout_d = alu_res_s;
        end else begin
            aluout_d = aluout_q;
        end
        if (ctl_s.mdr_we) begin
            mdr_d = mem_rdata;
        end else begin
            mdr_d = mdr_q;
        end
    end

    // Register file write port; $0 is never written
    always_comb begin
        rf_d = rf_q;
        if (wr_en_s) begin
            rf_d[wr_addr_s] = wr_data_s;
        end else begin
            rf_d = rf_q;
        end
    end

    // Datapath and register file state
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            aluout_q <= '0;
            mdr_q    <= '0;
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            a_q      <= a_d;
            b_q      <= b_d;
            aluout_q <= aluout_d;
            mdr_q    <= mdr_d;
            rf_q     <= rf_d;
        end
    end

    // While reset is held the bus and debug strobes stay quiet, abandoning any access
    assign mem_req        = rst ? 1'b0 : ctl_s.mem_req;
    assign mem_we         = rst ? 1'b0 : ctl_s.mem_we;
    assign mem_addr       = rst ? '0 : (ctl_s.iord ? aluout_q[ADDR_WIDTH+1:2] : pc_q[ADDR_WIDTH+1:2]);
    assign mem_wdata      = (rst || !ctl_s.mem_we) ? '0 : b_q;
    assign write_reg_en   = !rst && wr_en_s;
    assign write_reg_addr = (!rst && ctl_s.reg_write) ? wr_addr_s : 5'd0;
    assign write_reg_data = (!rst && ctl_s.reg_write) ? wr_data_s : '0;
    assign instr_retired  = !rst && ctl_s.retire;
    assign prog_count     = pc_q;
    assign instr_opcode   = ir_q[31:26];
    assign fsm_state      = state_s;

`ifdef MCP_PERF_CNT_EN
    logic [31:0] cycle_count_q, cycle_count_d;
    logic [31:0] retire_count_q, retire_count_d;

    // Counter increments; both wrap naturally at 2^32
    always_comb begin
        cycle_count_d = cycle_count_q + 32'd1;
        if (ctl_s.retire) begin
            retire_count_d = retire_count_q + 32'd1;
        end else begin
            retire_count_d = retire_count_q;
        end
    end

    // Performance counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_count_q  <= 32'd0;
            retire_count_q <= 32'd0;
        end else begin
            cycle_count_q  <= cycle_count_d;
            retire_count_q <= retire_count_d;
        end
    end

    assign cycle_count  = rst ? 32'd0 : cycle_count_q;
    assign retire_count = rst ? 32'd0 : retire_count_q;
`endif

endmodule

// File: tb/tb_multicycle_processor.sv
// Directed self-checking bench for multicycle_processor with a word memory
// model whose ready line is driven per cycle by the stimulus.
module tb_multicycle_processor;

    logic        clk;
    logic        rst;
    logic        mem_req;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic [31:0] prog_count;
    logic [5:0]  instr_opcode;
    logic [2:0]  fsm_state;
    logic        write_reg_en;
    logic [4:0]  write_reg_addr;
    logic [31:0] write_reg_data;
    logic        instr_retired;
`ifdef MCP_PERF_CNT_EN
    logic [31:0] cycle_count;
    logic [31:0] retire_count;
`endif

    multicycle_processor #(
        .WORD_SIZE  (32),
        .ADDR_WIDTH (8),
        .RESET_PC   (32'h0000_0040)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_ready      (mem_ready),
        .prog_count     (prog_count),
        .instr_opcode   (instr_opcode),
        .fsm_state      (fsm_state),
        .write_reg_en   (write_reg_en),
        .write_reg_addr (write_reg_addr),
        .write_reg_data (write_reg_data),
        .instr_retired  (instr_retired)
`ifdef MCP_PERF_CNT_EN
        ,
        .cycle_count    (cycle_count),
        .retire_count   (retire_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program image plus a write-back overlay for stored words
    logic [31:0] prog [0:255];
    bit   [31:0] dmem [0:255];
    bit   [255:0] dvalid;
    int          wr_count;

    assign mem_rdata = dvalid[mem_addr] ? dmem[mem_addr] : prog[mem_addr];

    // Memory write port: a store lands on the edge where req, ready and we meet
    always @(posedge clk) begin
        if (mem_req && mem_ready && mem_we) begin
            dmem[mem_addr]   <= mem_wdata;
            dvalid[mem_addr] <= 1'b1;
            wr_count         <= wr_count + 1;
        end
    end

    int          n_checks;
    int          n_bad;
    int          total_cyc;
    bit          wr_seen;
    logic [4:0]  wr_addr_seen;
    logic [31:0] wr_data_seen;
    bit          st_seen;
    logic [7:0]  st_addr_seen;
    logic [31:0] st_data_seen;
    bit          stable_ok;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    // Runs one instruction from its FETCH, stalling FETCH/MEM by the given counts
    task automatic run_instr(input string tag, input int fstall, input int mstall, input int exp_cyc);
        int          f;
        int          m;
        int          cyc;
        bit          done;
        bit          snap_v;
        logic [7:0]  s_addr;
        logic        s_we;
        logic [31:0] s_wdata;
        logic [31:0] s_pc;
        logic [5:0]  s_op;
        f = fstall; m = mstall; cyc = 0; done = 1'b0; snap_v = 1'b0;
        s_addr = 8'd0; s_we = 1'b0; s_wdata = 32'd0; s_pc = 32'd0; s_op = 6'd0;
        wr_seen = 1'b0; st_seen = 1'b0; stable_ok = 1'b1;
        while (!done && cyc < 40) begin
            if (fsm_state == 3'd0 && f > 0) begin
                mem_ready = 1'b0; f--;
            end else if (fsm_state == 3'd3 && m > 0) begin
                mem_ready = 1'b0; m--;
            end else begin
                mem_ready = 1'b1;
            end
            #1;
            if (!mem_ready) begin
                if (!snap_v) begin
                    s_addr = mem_addr; s_we = mem_we; s_wdata = mem_wdata;
                    s_pc = prog_count; s_op = instr_opcode; snap_v = 1'b1;
                end else if (mem_addr != s_addr || mem_we != s_we || mem_wdata != s_wdata ||
                             prog_count != s_pc || instr_opcode != s_op || !mem_req) begin
                    stable_ok = 1'b0;
                end
            end else begin
                snap_v = 1'b0;
            end
            if (write_reg_en) begin
                wr_seen = 1'b1; wr_addr_seen = write_reg_addr; wr_data_seen = write_reg_data;
            end
            if (mem_req && mem_ready && mem_we) begin
                st_seen = 1'b1; st_addr_seen = mem_addr; st_data_seen = mem_wdata;
            end
            done = instr_retired;
            @(posedge clk); #1;
            cyc++;
            total_cyc++;
        end
        check_val({tag, " retired"}, 32'(done), 32'd1);
        check_val({tag, " cycles"}, cyc, exp_cyc);
    endtask

    initial begin
        int          cyc;
        int          snap;
        n_checks = 0; n_bad = 0; total_cyc = 0;
        rst = 1'b1; mem_ready = 1'b1;
        for (int i = 0; i < 256; i++) prog[i] = 32'h0;
        prog[16] = enc_i(6'h08, 5'd0, 5'd1, 16'hFFFD);   // ADDI $1,$0,-3
        prog[17] = enc_r(5'd1, 5'd1, 5'd2, 6'h20);       // ADD  $2,$1,$1
        prog[18] = enc_i(6'h2B, 5'd0, 5'd2, 16'h0008);   // SW   $2,8($0)
        prog[19] = enc_i(6'h23, 5'd0, 5'd3, 16'h0008);   // LW   $3,8($0)
        prog[20] = enc_i(6'h23, 5'd0, 5'd4, 16'h0008);   // LW   $4,8($0) with stalls
        prog[21] = enc_r(5'd1, 5'd1, 5'd0, 6'h20);       // ADD  $0,$1,$1
        prog[22] = 32'hFC00_0000;                        // unknown opcode
        prog[23] = {6'h02, 26'd3};                       // J    0x0C
        prog[3]  = enc_i(6'h04, 5'd1, 5'd1, 16'hFFFF);   // BEQ  $1,$1,-1

        repeat (2) @(posedge clk);
        #1;
        check_val("rst mem_req", 32'(mem_req), 32'd0);
        check_val("rst retired", 32'(instr_retired), 32'd0);
        check_val("rst pc", prog_count, 32'h40);
        check_val("rst state", 32'(fsm_state), 32'd0);
        rst = 1'b0;
        #1;
        check_val("fetch0 mem_req", 32'(mem_req), 32'd1);
        check_val("fetch0 mem_we", 32'(mem_we), 32'd0);
        check_val("fetch0 addr", 32'(mem_addr), 32'h10);
        check_val("fetch0 wr_en", 32'(write_reg_en), 32'd0);
        check_val("fetch0 wr_addr", 32'(write_reg_addr), 32'd0);
        check_val("fetch0 wr_data", write_reg_data, 32'd0);

        run_instr("addi", 0, 0, 4);
        check_val("addi retire cycle", total_cyc, 32'd4);
        check_val("addi wr_addr", 32'(wr_addr_seen), 32'd1);
        check_val("addi wr_data", wr_data_seen, 32'hFFFF_FFFD);

        run_instr("add", 0, 0, 4);
        check_val("add retire cycle", total_cyc, 32'd8);
        check_val("add wr_addr", 32'(wr_addr_seen), 32'd2);
        check_val("add wr_data", wr_data_seen, 32'hFFFF_FFFA);

        run_instr("sw", 0, 0, 4);
        check_val("sw seen", 32'(st_seen), 32'd1);
        check_val("sw addr", 32'(st_addr_seen), 32'd2);
        check_val("sw data", st_data_seen, 32'hFFFF_FFFA);

        run_instr("lw", 0, 0, 5);
        check_val("lw wr_addr", 32'(wr_addr_seen), 32'd3);
        check_val("lw wr_data", wr_data_seen, 32'hFFFF_FFFA);

        run_instr("lw stall", 3, 3, 11);
        check_val("lw stall stable", 32'(stable_ok), 32'd1);
        check_val("lw stall wr_addr", 32'(wr_addr_seen), 32'd4);
        check_val("lw stall wr_data", wr_data_seen, 32'hFFFF_FFFA);

        run_instr("add r0", 0, 0, 4);
        check_val("add r0 no write", 32'(wr_seen), 32'd0);
        check_val("add r0 pc", prog_count, 32'h58);

        run_instr("nop", 0, 0, 2);
        check_val("nop pc", prog_count, 32'h5C);

        run_instr("j", 0, 0, 2);
        check_val("j pc", prog_count, 32'h0C);

        run_instr("beq taken", 0, 0, 3);
        check_val("beq taken pc", prog_count, 32'h0C);
        check_val("beq taken fetch addr", 32'(mem_addr), 32'h03);

        rst = 1'b1;
        prog[16] = enc_i(6'h08, 5'd0, 5'd1, 16'h0005);   // ADDI $1,$0,5
        prog[17] = {6'h02, 26'd3};                       // J    0x0C
        prog[3]  = enc_i(6'h04, 5'd1, 5'd0, 16'hFFFF);   // BEQ  $1,$0,-1
        prog[4]  = enc_i(6'h2B, 5'd0, 5'd1, 16'h0000);   // SW   $1,0($0)
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        run_instr("addi5", 0, 0, 4);
        run_instr("j2", 0, 0, 2);
        run_instr("beq not taken", 0, 0, 3);
        check_val("beq not taken pc", prog_count, 32'h10);

        mem_ready = 1'b1;
        cyc = 0;
        while (fsm_state != 3'd3 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_val("sw reach mem", 32'(fsm_state), 32'd3);
        mem_ready = 1'b0;
        #1;
        check_val("sw pending we", 32'(mem_we), 32'd1);
        check_val("sw pending addr", 32'(mem_addr), 32'd0);
        check_val("sw pending data", mem_wdata, 32'd5);
        snap = wr_count;
        rst = 1'b1;
        mem_ready = 1'b1;
        #1;
        check_val("rst forces mem_req", 32'(mem_req), 32'd0);
        @(posedge clk); #1;
        check_val("rst no write", wr_count, snap);
        check_val("rst mid-mem pc", prog_count, 32'h40);
        check_val("rst mid-mem state", 32'(fsm_state), 32'd0);
        rst = 1'b0;
        #1;
        check_val("restart fetch addr", 32'(mem_addr), 32'h10);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
